// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register file slave: byte strobes, read-only status registers, SLVERR decode, registered reads.
// Optional macro AXI_LITE_REGFILE_ERR_IRQ_EN adds irq_o, a sticky error interrupt.
module axi_lite_regfile_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [ADDR_WIDTH-1:0]          awaddr_i,
    input  logic                           awvalid_i,
    output logic                           awready_o,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic                           wvalid_i,
    output logic                           wready_o,
    output logic [1:0]                     bresp_o,
    output logic                           bvalid_o,
    input  logic                           bready_i,
    input  logic [ADDR_WIDTH-1:0]          araddr_i,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [1:0]                     rresp_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_d_i
`ifdef AXI_LITE_REGFILE_ERR_IRQ_EN
   ,output logic                           irq_o
`endif
);

    localparam int unsigned STRB_W      = DATA_WIDTH / 8;
    localparam int unsigned LSB         = $clog2(STRB_W);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("axi_lite_regfile_slave: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 2) begin : g_bad_nregs
        $error("axi_lite_regfile_slave: NUM_REGS must be at least 2");
    end

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e r_wstate, w_wstate_nxt;
    rstate_e r_rstate, w_rstate_nxt;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_aw_vld;
    logic                  r_w_vld;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic                  w_b_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [ADDR_WIDTH:0]   w_woff;
    logic [ADDR_WIDTH:0]   w_roff;
    logic [ADDR_WIDTH-1:0] w_widx;
    logic [ADDR_WIDTH-1:0] w_ridx;
    logic                  w_win;
    logic                  w_rin;
    logic                  w_wr_ro;
    logic                  w_wr_err;
    logic [NUM_REGS-1:0]   w_reg_we;
    logic [DATA_WIDTH-1:0] w_rd_val;

    // Range check uses the borrow of (addr - BASE_ADDR) so no constant compare is needed.
    assign w_woff   = {1'b0, r_aw_addr} - {1'b0, BASE_ADDR};
    assign w_roff   = {1'b0, araddr_i}  - {1'b0, BASE_ADDR};
    assign w_widx   = w_woff[ADDR_WIDTH-1:0] >> LSB;
    assign w_ridx   = w_roff[ADDR_WIDTH-1:0] >> LSB;
    assign w_win    = !w_woff[ADDR_WIDTH] && (w_widx < ADDR_WIDTH'(NUM_REGS));
    assign w_rin    = !w_roff[ADDR_WIDTH] && (w_ridx < ADDR_WIDTH'(NUM_REGS));

    assign w_aw_hs  = awvalid_i && awready_o;
    assign w_w_hs   = wvalid_i && wready_o;
    assign w_commit = (r_wstate == W_IDLE) && r_aw_vld && r_w_vld;
    assign w_b_hs   = (r_wstate == W_RESP) && bready_i;
    assign w_ar_hs  = arvalid_i && arready_o;
    assign w_r_hs   = (r_rstate == R_DATA) && rready_i;
    assign w_wr_err = !w_win || w_wr_ro;

    always_comb begin
        w_wr_ro  = 1'b0;
        w_reg_we = '0;
        w_rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_widx == ADDR_WIDTH'(i)) begin
                w_wr_ro     = RO_MASK[i];
                w_reg_we[i] = w_commit && w_win && !RO_MASK[i];
            end
            if (w_ridx == ADDR_WIDTH'(i)) begin
                w_rd_val = RO_MASK[i] ? ro_d_i[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    // Write FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: if (r_aw_vld && r_w_vld) w_wstate_nxt = W_RESP;
            W_RESP: if (bready_i) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: if (arvalid_i) w_rstate_nxt = R_DATA;
            R_DATA: if (rready_i) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Handshake outputs depend only on state and holding flags.
    always_comb begin
        awready_o = (r_wstate == W_IDLE) && !r_aw_vld;
        wready_o  = (r_wstate == W_IDLE) && !r_w_vld;
        bvalid_o  = (r_wstate == W_RESP);
        arready_o = (r_rstate == R_IDLE);
        rvalid_o  = (r_rstate == R_DATA);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_vld  <= 1'b0;
            r_w_vld   <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else if (w_b_hs) begin
            r_aw_vld <= 1'b0;
            r_w_vld  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_vld  <= 1'b1;
                r_aw_addr <= awaddr_i;
            end
            if (w_w_hs) begin
                r_w_vld  <= 1'b1;
                r_w_data <= wdata_i;
                r_w_strb <= wstrb_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_bresp <= RESP_OKAY;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (w_reg_we[i] && r_w_strb[b]) begin
                        r_regs[i][b*8 +: 8] <= r_w_data[b*8 +: 8];
                    end
                end
            end
            if (w_commit) begin
                r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read data is captured from pre-edge register state, so a same-edge write is not visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rin ? w_rd_val : '0;
            r_rresp <= w_rin ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign bresp_o = r_bresp;
    assign rdata_o = r_rdata;
    assign rresp_o = r_rresp;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[g] ? ro_d_i[g*DATA_WIDTH +: DATA_WIDTH] : r_regs[g];
    end

`ifdef AXI_LITE_REGFILE_ERR_IRQ_EN
    logic r_irq;
    logic w_irq_set;
    logic w_irq_clr;

    assign w_irq_set = (w_commit && w_wr_err) || (w_ar_hs && !w_rin);
    assign w_irq_clr = w_commit && !w_wr_err && (w_widx == '0) && r_w_strb[0] && r_w_data[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (w_irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Scoreboard bench for axi_lite_regfile_slave: expected B/R responses are queued by stimulus and
// checked by an independent monitor on each handshake; RO_MASK marks register 3 read-only.
module tb_axi_lite_regfile_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic         clk;
    logic         rst_n;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] reg_q;
    logic [255:0] ro_d;
    logic         irq;
    logic         irq_pre;
    logic         irq_bv;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] bq[$];
    rexp_t      rq[$];

    axi_lite_regfile_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (8),
        .BASE_ADDR  (32'h0),
        .RO_MASK    (8'b0000_1000)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .awaddr_i  (awaddr),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .araddr_i  (araddr),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .reg_q_o   (reg_q),
        .ro_d_i    (ro_d)
`ifdef AXI_LITE_REGFILE_ERR_IRQ_EN
       ,.irq_o     (irq)
`endif
    );

`ifndef AXI_LITE_REGFILE_ERR_IRQ_EN
    assign irq = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every B and R handshake against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                chk("b_expected", (bq.size() != 0), 1);
                if (bq.size() != 0) chk("bresp", bresp, bq.pop_front());
            end
            if (rvalid && rready) begin
                chk("r_expected", (rq.size() != 0), 1);
                if (rq.size() != 0) begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("rresp", rresp, e.r);
                end
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", bq.size() + rq.size(), 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] ed,
                           input logic [1:0] er, input int hold);
        int n;
        rq.push_back('{d: ed, r: er});
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accept", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("r_latency", rvalid, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_data", rdata, ed);
            chk("r_hold_resp", rresp, er);
            chk("r_hold_arready", arready, 0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            rready = 1'b1;
        end
        wait_drain();
    endtask

    // W is presented 'lead' cycles before AW (0 = same cycle).
    task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input logic [1:0] er);
        logic wa, aa, w_done, a_done;
        int   cyc;
        bq.push_back(er);
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        awaddr  = addr;
        awvalid = (lead == 0);
        w_done  = 1'b0;
        a_done  = 1'b0;
        cyc     = 0;
        while (!(w_done && a_done) && cyc < 50) begin
            @(negedge clk);
            wa = wvalid && wready;
            aa = awvalid && awready;
            @(posedge clk); #1;
            cyc++;
            if (wa) begin wvalid = 1'b0; w_done = 1'b1; end
            if (aa) begin awvalid = 1'b0; a_done = 1'b1; end
            if (!a_done && cyc >= lead) awvalid = 1'b1;
        end
        chk("w_accept", (w_done && a_done), 1);
        chk("b_latency_pre", bvalid, 0);
        irq_pre = irq;
        @(posedge clk); #1;
        chk("b_latency", bvalid, 1);
        irq_bv = irq;
        wait_drain();
    endtask

    initial begin
        rst_n   = 1'b0;
        awaddr  = '0; awvalid = 1'b0;
        wdata   = '0; wstrb   = '0; wvalid = 1'b0;
        araddr  = '0; arvalid = 1'b0;
        bready  = 1'b1; rready = 1'b1;
        ro_d    = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_reg_q", reg_q[127:0], 0);
        chk("rst_irq", irq, 0);

        do_read(32'h8, 32'h0, OKAY, 0);

        do_write(32'h4, 32'hDEADBEEF, 4'b0101, 3, OKAY);
        do_read(32'h4, 32'h00AD00EF, OKAY, 0);
        chk("reg_q1", reg_q[63:32], 32'h00AD00EF);

        do_write(32'hC, 32'h12345678, 4'hF, 0, SLVERR);
        chk("ro_unchanged", reg_q[127:96], 32'h0);
        ro_d[127:96] = 32'hCAFE0001;
        #1 chk("ro_reg_q", reg_q[127:96], 32'hCAFE0001);
        do_read(32'hC, 32'hCAFE0001, OKAY, 0);

        do_read(32'h40, 32'h0, SLVERR, 4);

        do_write(32'h8, 32'hFFFFFFFF, 4'b0000, 0, OKAY);
        do_read(32'h8, 32'h0, OKAY, 0);
        do_write(32'h8, 32'h11223344, 4'b1000, 1, OKAY);
        do_write(32'hA, 32'hAABBCCDD, 4'b0001, 0, OKAY);
        do_read(32'h9, 32'h110000DD, OKAY, 0);
        do_write(32'h1C, 32'h00000077, 4'hF, 2, OKAY);
        do_read(32'h1C, 32'h00000077, OKAY, 0);
        do_write(32'h20, 32'h1, 4'hF, 0, SLVERR);
        do_read(32'h20, 32'h0, SLVERR, 0);

        // Same-edge write commit and read of register 1
        do_write(32'h4, 32'h0000005A, 4'hF, 0, OKAY);
        bready = 1'b0;
        bq.push_back(OKAY);
        rq.push_back('{d: 32'h5A, r: OKAY});
        awaddr = 32'h4; awvalid = 1'b1;
        wdata  = 32'hA5; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr  = 32'h4; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("same_edge_rvalid", rvalid, 1);
        chk("same_edge_bvalid", bvalid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bhold_awready", awready, 0);
            chk("bhold_wready", wready, 0);
            chk("bhold_bvalid", bvalid, 1);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        wait_drain();
        do_read(32'h4, 32'hA5, OKAY, 0);

`ifdef AXI_LITE_REGFILE_ERR_IRQ_EN
        do_write(32'h0, 32'h1, 4'b0001, 0, OKAY);
        chk("irq_sticky", irq_pre, 1);
        chk("irq_clear", irq_bv, 0);
        chk("reg_q0", reg_q[31:0], 32'h1);
        do_write(32'h40, 32'h0, 4'hF, 0, SLVERR);
        chk("irq_before_err", irq_pre, 0);
        chk("irq_at_bvalid", irq_bv, 1);
`endif

        // Reset while a response is pending
        bready = 1'b0;
        awaddr = 32'h40; awvalid = 1'b1;
        wdata  = 32'h0;  wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        chk("pend_bvalid", bvalid, 1);
`ifdef AXI_LITE_REGFILE_ERR_IRQ_EN
        chk("pend_irq", irq, 1);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_awready", awready, 1);
        chk("mid_rst_reg_q", reg_q[95:0], 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_bvalid", bvalid, 0);
        end
        chk("post_rst_queues", bq.size() + rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
Parametrised AXI4-Lite slave holding NUM_REGS registers of DATA_WIDTH bits. It is the successor to the fixed single-IP AXI endpoint. Adds the following:
- independent AW/W acceptance
- byte strobes
- read-only hardware status registers
- SLVERR decode
- registered read data

It sits behind the SoC AXI-Lite demux as a generic control/status block for custom peripherals.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, register and bus data width. Must be 32 or 64.
- NUM_REGS, 8, number of registers. Must be ≥2.
- BASE_ADDR, 32'h0, byte address of register 0.
- RO_MASK, 'b0, NUM_REGS-bit mask. Bit i=1 makes register i read-only, driven by ro_d_i.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- awaddr_i  in  ADDR_WIDTH  write address
- awvalid_i  in  1
- awready_o  out  1
- wdata_i  in  DATA_WIDTH
- wstrb_i  in  DATA_WIDTH/8
- wvalid_i  in  1
- wready_o  out  1
- bresp_o  out  2  00 OKAY, 10 SLVERR
- bvalid_o  out  1
- bready_i  in  1
- araddr_i  in  ADDR_WIDTH
- arvalid_i  in  1
- arready_o  out  1
- rdata_o  out  DATA_WIDTH
- rresp_o  out  2
- rvalid_o  out  1
- rready_i  in  1
- reg_q_o  out  NUM_REGS*DATA_WIDTH  flattened register contents, reg i at [i*DW +: DW]
- ro_d_i  in  NUM_REGS*DATA_WIDTH  hardware values for read-only registers

Behaviour:
- Reset (async, rst_ni low):
  - all registers clear to 0
  - awready_o=1, wready_o=1, arready_o=1
  - bvalid_o=0, rvalid_o=0
  - bresp_o=00, rresp_o=00, rdata_o=0
- Decode: idx = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored. The address is in range iff addr ≥ BASE_ADDR and idx < NUM_REGS.
- Write path, states W_IDLE / W_RESP:
  - In W_IDLE, AW and W are accepted independently, in either order or in the same cycle. Each is latched into a holding register with a valid flag.
  - After its beat is latched, the corresponding ready drops to 0 until the response completes.
  - When both flags are set, the write commits on the next edge and the FSM enters W_RESP with bvalid_o=1.
  - Commit rules:
    - In-range writable register: each byte lane with wstrb=1 is updated; bresp=OKAY.
    - Out-of-range address or RO_MASK register: no update; bresp=SLVERR.
    - wstrb all zero to a valid register: OKAY, no update.
  - bvalid_o, bresp_o hold until bready_i. On the handshake edge: return to W_IDLE, both readies go to 1, flags clear.
  - Latency: AW and W both presented in cycle 0 gives bvalid in cycle 2. bready held high frees the path in cycle 3.
- Read path, states R_IDLE / R_DATA:
  - arready_o=1 only in R_IDLE.
  - On the AR handshake, rdata_o/rresp_o are registered and rvalid_o=1 on the next cycle.
  - Read sources:
    - Writable register: register value.
    - RO register: ro_d_i slice sampled at the handshake edge.
    - Out of range: rdata=0, SLVERR.
  - rdata/rresp/rvalid hold stable until rready_i, then return to R_IDLE. No new AR is accepted while in R_DATA.
- Read and write paths are fully concurrent. If a read handshake and a write commit to the same register occur on the same edge, the read returns the pre-write value.
- reg_q_o always reflects the stored values. For RO registers it equals the ro_d_i slice.
- Reset asserted mid-transaction aborts all state immediately and drops pending responses. No response is generated after reset.
- Outputs must not depend combinationally on valid/ready inputs; every ready and valid is registered.

Optional Feature:
- Macro: AXI_LITE_REGFILE_ERR_IRQ_EN.
- When defined:
  - Adds output port irq_o (1 bit, reset 0).
  - irq_o is a sticky flag, set on the edge where any SLVERR response is issued (bvalid or rvalid rising with SLVERR).
  - It clears on a successful write to register 0 with wstrb_i[0]=1 and wdata_i[0]=1; that write also updates register 0 normally.
  - If a set event and a clear event fall on the same edge, set wins.
- When undefined: no irq_o port; SLVERR responses are unchanged.

Test Plan:
- Reset, then read idx 2 (addr 0x8) → rdata=0, OKAY, rvalid one cycle after AR handshake.
- W beat data 0xDEADBEEF strb 4'b0101 presented 3 cycles before AW to 0x4 → bvalid 2 cycles after AW acceptance, OKAY; read 0x4 → 0x00AD00EF.
- With RO_MASK bit 3 set: write 0x12345678 to 0xC → SLVERR, reg unchanged. Drive ro_d_i slice 3=0xCAFE0001, read 0xC → 0xCAFE0001, OKAY.
- Read 0x40 with NUM_REGS=8 → rdata=0, SLVERR. Hold rready low 4 cycles → rvalid/rdata stable, arready=0 throughout.
- Same-edge write 0xA5 to idx 1 and read idx 1 (old value 0x5A) → read returns 0x5A; next read returns 0xA5. bready low 5 cycles → awready/wready stay 0.
- AXI_LITE_REGFILE_ERR_IRQ_EN: out-of-range write → irq_o=1 from bvalid edge. Write 0x1 strb 0x1 to idx 0 → irq_o=0 next cycle. Assert rst_ni mid-response → bvalid=0 and irq_o=0 immediately.
